// File: rtl/reg_dump_ctrl_pkg.sv
// Shared types and encodings for the DLX register-dump debug sequencer.
package dlx_dbg_pkg;

   typedef enum logic [2:0] {
      IDLE,
      DRAIN,
      ISSUE,
      WAIT,
      PRESENT,
      DONE
   } dbg_state_e;

   localparam logic [5:0]  OPC_ADDI = 6'b001000;
   localparam logic [31:0] DBG_NOP  = 32'h0;
   localparam logic [4:0]  LAST_IDX = 5'd31;

   // addi r0, r<idx>, 0 : reads r<idx> on port A and writes only r0.
   function automatic logic [31:0] probe_inst(input logic [4:0] idx);
      return {OPC_ADDI, idx, 5'b00000, 16'h0000};
   endfunction

endpackage

// File: rtl/reg_dump_ctrl_if.sv
// Control, probe and record-stream signals between the dump sequencer and the CPU/sink side.
interface reg_dump_ctrl_if;
   logic        start;
   logic [31:0] busA_probe;
   logic        dump_ready;
   logic        override_inst;
   logic [31:0] force_inst;
   logic        busy;
   logic        dump_valid;
   logic [4:0]  dump_reg;
   logic [31:0] dump_val;
   logic        done;

   modport master (
      input  start, busA_probe, dump_ready,
      output override_inst, force_inst, busy, dump_valid, dump_reg, dump_val, done
   );

   modport slave (
      output start, busA_probe, dump_ready,
      input  override_inst, force_inst, busy, dump_valid, dump_reg, dump_val, done
   );
endinterface

// File: rtl/reg_dump_ctrl_timer.sv
// Loadable 8-bit down-counter with a zero flag; saturates at zero.
module dbg_timer (
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  logic [7:0] load_val,
   input  logic       en,
   output logic       zero
);

   logic [7:0] count_q;
   logic [7:0] count_d;

   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_val;
      end else if (en && (count_q != 8'd0)) begin
         count_d = count_q - 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= 8'd0;
      end else begin
         count_q <= count_d;
      end
   end

   assign zero = (count_q == 8'd0);

endmodule

// File: rtl/reg_dump_ctrl.sv
// Register-file dump sequencer driving the DLX instruction-override mux.
// Define REG_DUMP_SKIP_R0_EN to start the dump at r1 instead of r0.
module reg_dump_ctrl
   import dlx_dbg_pkg::*;
#(
   parameter int unsigned DRAIN_CYCLES = 4,
   parameter int unsigned CAPTURE_LAT  = 1
) (
   input  logic              clk,
   input  logic              reset,
   reg_dump_ctrl_if.master   dbg
);

`ifdef REG_DUMP_SKIP_R0_EN
   localparam logic [4:0] FIRST_IDX = 5'd1;
`else
   localparam logic [4:0] FIRST_IDX = 5'd0;
`endif

   // Timer holds "cycles remaining after this one", so the phase ends when it reads zero.
   localparam logic [7:0] DRAIN_LOAD = 8'(DRAIN_CYCLES - 1);
   localparam logic [7:0] WAIT_LOAD  = 8'(CAPTURE_LAT - 1);

   dbg_state_e  state_q, state_d;
   logic [4:0]  idx_q, idx_d;
   logic        override_q, override_d;
   logic [31:0] force_q, force_d;
   logic        busy_q, busy_d;
   logic        valid_q, valid_d;
   logic [4:0]  dump_reg_q, dump_reg_d;
   logic [31:0] dump_val_q, dump_val_d;
   logic        done_q, done_d;

   logic        tmr_load;
   logic [7:0]  tmr_val;
   logic        tmr_zero;

   dbg_timer u_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (tmr_load),
      .load_val (tmr_val),
      .en       (1'b1),
      .zero     (tmr_zero)
   );

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      tmr_load   = 1'b0;
      tmr_val    = 8'd0;
      dump_reg_d = dump_reg_q;
      dump_val_d = dump_val_q;

      case (state_q)
         IDLE: begin
            if (dbg.start) begin
               state_d  = DRAIN;
               idx_d    = FIRST_IDX;
               tmr_load = 1'b1;
               tmr_val  = DRAIN_LOAD;
            end
         end
         DRAIN: begin
            if (tmr_zero) state_d = ISSUE;
         end
         ISSUE: begin
            state_d  = WAIT;
            tmr_load = 1'b1;
            tmr_val  = WAIT_LOAD;
         end
         WAIT: begin
            if (tmr_zero) begin
               state_d    = PRESENT;
               dump_reg_d = idx_q;
               dump_val_d = dbg.busA_probe;
            end
         end
         PRESENT: begin
            if (dbg.dump_ready) begin
               if (idx_q == LAST_IDX) begin
                  state_d = DONE;
               end else begin
                  state_d = ISSUE;
                  idx_d   = idx_q + 5'd1;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Outputs are decoded from the next state so they are registered with it.
      override_d = (state_d != IDLE);
      busy_d     = (state_d != IDLE);
      valid_d    = (state_d == PRESENT);
      done_d     = (state_d == DONE);
      force_d    = DBG_NOP;
      if ((state_d == ISSUE) || (state_d == WAIT) || (state_d == PRESENT)) begin
         force_d = probe_inst(idx_d);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         idx_q      <= FIRST_IDX;
         override_q <= 1'b0;
         force_q    <= DBG_NOP;
         busy_q     <= 1'b0;
         valid_q    <= 1'b0;
         dump_reg_q <= 5'd0;
         dump_val_q <= 32'd0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         override_q <= override_d;
         force_q    <= force_d;
         busy_q     <= busy_d;
         valid_q    <= valid_d;
         dump_reg_q <= dump_reg_d;
         dump_val_q <= dump_val_d;
         done_q     <= done_d;
      end
   end

   assign dbg.override_inst = override_q;
   assign dbg.force_inst    = force_q;
   assign dbg.busy          = busy_q;
   assign dbg.dump_valid    = valid_q;
   assign dbg.dump_reg      = dump_reg_q;
   assign dbg.dump_val      = dump_val_q;
   assign dbg.done          = done_q;

endmodule

// File: tb/tb_reg_dump_ctrl.sv
// Bench for reg_dump_ctrl: default instance (4/1) and a swept instance (1/3) against a pipeline/register model.
module tb_reg_dump_ctrl;

   localparam int DA = 4;
   localparam int LA = 1;
   localparam int DB = 1;
   localparam int LB = 3;

`ifdef REG_DUMP_SKIP_R0_EN
   localparam int FIRST = 1;
`else
   localparam int FIRST = 0;
`endif
   localparam int NREC = 32 - FIRST;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_fail;

   reg_dump_ctrl_if ifa ();
   reg_dump_ctrl_if ifb ();

   reg_dump_ctrl #(.DRAIN_CYCLES(DA), .CAPTURE_LAT(LA)) dut_a (
      .clk (clk), .reset (reset), .dbg (ifa.master)
   );
   reg_dump_ctrl #(.DRAIN_CYCLES(DB), .CAPTURE_LAT(LB)) dut_b (
      .clk (clk), .reset (reset), .dbg (ifb.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pipeline model: read port A shows, LAT cycles later, the register named by an addi probe.
   logic [31:0] regs   [32];
   logic [31:0] hist_a [16];
   logic [31:0] hist_b [16];

   always @(posedge clk) begin
      for (int i = 15; i > 0; i--) begin
         hist_a[i] <= hist_a[i-1];
         hist_b[i] <= hist_b[i-1];
      end
      hist_a[0] <= ifa.force_inst;
      hist_b[0] <= ifb.force_inst;
   end

   assign ifa.busA_probe = (hist_a[LA-1][31:26] == 6'b001000 && hist_a[LA-1][20:0] == 21'd0)
                           ? regs[hist_a[LA-1][25:21]] : 32'hBAD0_BAD0;
   assign ifb.busA_probe = (hist_b[LB-1][31:26] == 6'b001000 && hist_b[LB-1][20:0] == 21'd0)
                           ? regs[hist_b[LB-1][25:21]] : 32'hBAD0_BAD0;

   int rec_reg [$];
   int rec_val [$];
   int rec_cyc [$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] exp_inst(input int k);
      logic [4:0] r;
      r = 5'(k);
      return {6'b001000, r, 21'd0};
   endfunction

   function automatic logic [31:0] exp_val(input int k);
      return (k == 0) ? 32'd0 : regs[k];
   endfunction

   // Runs one dump on instance A. Returns early (done_cyc = -1) when reset is injected.
   task automatic run_a(input int stall_rec, input int stall_n, input bit rand_ready,
                        input int again_cyc, input int rst_rec,
                        output int stalls, output int done_cyc);
      int  left;
      bit  pv;
      int  preg;
      int  pval;
      rec_reg.delete(); rec_val.delete(); rec_cyc.delete();
      stalls = 0; done_cyc = -1; left = stall_n; pv = 0; preg = 0; pval = 0;
      chk("idle_before_start", 32'(ifa.busy), 32'd0);
      ifa.start = 1'b1;
      ifa.dump_ready = 1'b1;
      for (int cyc = 1; cyc <= 600; cyc++) begin
         @(negedge clk);
         ifa.start = (cyc == again_cyc);
         if (pv) begin
            chk("hold_valid", 32'(ifa.dump_valid), 32'd1);
            chk("hold_reg", 32'(ifa.dump_reg), 32'(preg));
            chk("hold_val", ifa.dump_val, 32'(pval));
         end
         if (cyc == DA + 1) chk("a_first_issue", ifa.force_inst, exp_inst(FIRST));
         if (ifa.dump_valid && rst_rec >= 0 && int'(ifa.dump_reg) == rst_rec) begin
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            chk("rst_override", 32'(ifa.override_inst), 32'd0);
            chk("rst_valid", 32'(ifa.dump_valid), 32'd0);
            chk("rst_busy", 32'(ifa.busy), 32'd0);
            chk("rst_force", ifa.force_inst, 32'd0);
            chk("rst_done", 32'(ifa.done), 32'd0);
            return;
         end
         if (!ifa.dump_valid) ifa.dump_ready = 1'b1;
         else if (int'(ifa.dump_reg) == stall_rec && left > 0) begin
            ifa.dump_ready = 1'b0;
            left--;
         end else if (rand_ready) ifa.dump_ready = ($urandom_range(0, 3) != 0);
         else ifa.dump_ready = 1'b1;
         if (ifa.dump_valid && !ifa.dump_ready) stalls++;
         pv   = ifa.dump_valid && !ifa.dump_ready;
         preg = int'(ifa.dump_reg);
         pval = int'(ifa.dump_val);
         if (ifa.dump_valid && ifa.dump_ready) begin
            rec_reg.push_back(int'(ifa.dump_reg));
            rec_val.push_back(int'(ifa.dump_val));
            rec_cyc.push_back(cyc);
         end
         if (ifa.done) begin
            done_cyc = cyc;
            @(negedge clk);
            ifa.start = 1'b0;
            chk("busy_fall", 32'(ifa.busy), 32'd0);
            repeat (3) @(negedge clk);
            chk("no_queued_start", 32'(ifa.busy), 32'd0);
            return;
         end
      end
      ifa.start = 1'b0;
      chk("done_timeout", 32'd0, 32'd1);
   endtask

   task automatic check_records(input int n, input bit timed, input int d, input int l);
      chk("rec_count", 32'(rec_reg.size()), 32'(n));
      for (int k = 0; k < rec_reg.size() && k < n; k++) begin
         chk("rec_reg", 32'(rec_reg[k]), 32'(FIRST + k));
         chk("rec_val", 32'(rec_val[k]), exp_val(FIRST + k));
         if (timed) chk("rec_cycle", 32'(rec_cyc[k]), 32'(d + (k + 1) * (l + 2)));
      end
   endtask

   task automatic run_b(output int done_cyc);
      rec_reg.delete(); rec_val.delete(); rec_cyc.delete();
      done_cyc = -1;
      ifb.start = 1'b1;
      ifb.dump_ready = 1'b1;
      for (int cyc = 1; cyc <= 400; cyc++) begin
         @(negedge clk);
         ifb.start = 1'b0;
         if (cyc == DB + 1) chk("b_first_issue", ifb.force_inst, exp_inst(FIRST));
         if (ifb.dump_valid) begin
            rec_reg.push_back(int'(ifb.dump_reg));
            rec_val.push_back(int'(ifb.dump_val));
            rec_cyc.push_back(cyc);
         end
         if (ifb.done) begin
            done_cyc = cyc;
            return;
         end
      end
      chk("b_done_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      int stalls;
      int done_cyc;
      n_checks = 0;
      n_fail   = 0;
      reset = 1'b1;
      ifa.start = 1'b0; ifa.dump_ready = 1'b1;
      ifb.start = 1'b0; ifb.dump_ready = 1'b1;
      regs[0] = 32'd0;
      for (int k = 1; k < 32; k++) regs[k] = 32'hA5A5_0000 + 32'(k);
      repeat (4) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      chk("reset_override", 32'(ifa.override_inst), 32'd0);
      chk("reset_force", ifa.force_inst, 32'd0);
      chk("reset_busy", 32'(ifa.busy), 32'd0);
      chk("reset_valid", 32'(ifa.dump_valid), 32'd0);
      chk("reset_reg", 32'(ifa.dump_reg), 32'd0);
      chk("reset_val", ifa.dump_val, 32'd0);
      chk("reset_done", 32'(ifa.done), 32'd0);
      chk("reset_b_busy", 32'(ifb.busy), 32'd0);

      // Preload pattern, ready held high, second start in cycle 20 must be ignored.
      run_a(-1, 0, 1'b0, 20, -1, stalls, done_cyc);
      check_records(NREC, 1'b1, DA, LA);
      chk("done_cycle", 32'(done_cyc), 32'(DA + NREC * (LA + 2) + 1));

      // Random register contents, three-cycle stall on record 5.
      for (int k = 1; k < 32; k++) regs[k] = $urandom;
      @(negedge clk);
      run_a(5, 3, 1'b0, -1, -1, stalls, done_cyc);
      check_records(NREC, 1'b0, DA, LA);
      chk("stall_count", 32'(stalls), 32'd3);
      chk("done_late", 32'(done_cyc), 32'(DA + NREC * (LA + 2) + 1 + 3));

      // Random backpressure throughout.
      for (int k = 1; k < 32; k++) regs[k] = $urandom;
      @(negedge clk);
      run_a(-1, 0, 1'b1, -1, -1, stalls, done_cyc);
      check_records(NREC, 1'b0, DA, LA);
      chk("done_rand", 32'(done_cyc), 32'(DA + NREC * (LA + 2) + 1 + stalls));

      // Reset while record 10 is presented, then a fresh dump from the start index.
      @(negedge clk);
      run_a(-1, 0, 1'b0, -1, 10, stalls, done_cyc);
      chk("rst_partial_count", 32'(rec_reg.size()), 32'(10 - FIRST));
      @(negedge clk);
      run_a(-1, 0, 1'b0, -1, -1, stalls, done_cyc);
      check_records(NREC, 1'b1, DA, LA);
      chk("restart_done", 32'(done_cyc), 32'(DA + NREC * (LA + 2) + 1));

      // Swept instance: 1 drain cycle, 3-cycle capture latency, 5-cycle record period.
      for (int k = 1; k < 32; k++) regs[k] = $urandom;
      @(negedge clk);
      run_b(done_cyc);
      check_records(NREC, 1'b1, DB, LB);
      chk("b_done_cycle", 32'(done_cyc), 32'(DB + NREC * (LB + 2) + 1));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
